// File: rtl/jtag_az_generator_mc.sv
// Multi-channel autozeroing PWM generator: one master HIGH/LOW level L feeds a
// shared delay line, and every channel taps it at its own phase delay.
module jtag_az_generator_mc #(
  parameter int   NCH        = 4,
  parameter int   HIGH_W     = 8,
  parameter int   LOW_W      = 14,
  parameter int   PHASE_W    = 5,
  parameter int   BURST_W    = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                     TCK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     STOP,
  input  logic [1:0]               MODE,
  input  logic [HIGH_W-1:0]        NHIGH,
  input  logic [LOW_W-1:0]         NLOW,
  input  logic [BURST_W-1:0]       NBURST,
  input  logic [NCH*PHASE_W-1:0]   PHASE,
  input  logic [NCH-1:0]           CH_EN,
  output logic [NCH-1:0]           PHI_AZ,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [BURST_W-1:0]       PULSE_CNT,
  output logic [1:0]               STATE_DBG
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HIGH   = 2'd1;
  localparam logic [1:0] S_LOW    = 2'd2;
  localparam logic [1:0] M_BURST  = 2'd1;
  localparam logic [1:0] M_SINGLE = 2'd2;
  localparam int         DEPTH    = 2 ** PHASE_W;

  logic [1:0]         state_q, state_d;
  logic [HIGH_W-1:0]  hcnt_q, hcnt_d;
  logic [LOW_W-1:0]   lcnt_q, lcnt_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic [HIGH_W-1:0]  nhigh_q;
  logic [LOW_W-1:0]   nlow_q;
  logic [BURST_W-1:0] nburst_q;
  logic [1:0]         mode_q;
  logic               lvl_q, lvl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DEPTH-2:0]   dl_q;
  logic [DEPTH-1:0]   taps;
  logic [NCH-1:0]     phi_q, phi_d;
  logic               start_ok;
  logic               hlast, llast;
  logic [BURST_W-1:0] pcnt_inc;

  // Lengths are stored already guarded against zero, so "length-1" never underflows.
  assign start_ok = START & ~STOP & (state_q == S_IDLE);
  assign hlast    = (hcnt_q == nhigh_q - HIGH_W'(1));
  assign llast    = (lcnt_q == nlow_q - LOW_W'(1));
  assign pcnt_inc = pcnt_q + BURST_W'(1);
  assign taps     = {dl_q, lvl_q};

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_HIGH;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_HIGH: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (hlast) begin
          state_d = S_LOW;
          lcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HIGH_W'(1);
        end
      end
      S_LOW: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (llast) begin
          pcnt_d = pcnt_inc;
          if (mode_q == M_SINGLE || (mode_q == M_BURST && pcnt_inc == nburst_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
            hcnt_d  = '0;
          end
        end else begin
          lcnt_d = lcnt_q + LOW_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_d)
      S_HIGH:  lvl_d = 1'b1;
      S_LOW:   lvl_d = 1'b0;
      default: lvl_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Tap 0 is L itself; the output register supplies the extra cycle of delay.
  always_comb begin
    phi_d = '0;
    for (int k = 0; k < NCH; k++) begin
      phi_d[k] = CH_EN[k] ? taps[PHASE[k*PHASE_W +: PHASE_W]] : IDLE_LEVEL;
    end
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      pcnt_q   <= '0;
      nhigh_q  <= HIGH_W'(1);
      nlow_q   <= LOW_W'(1);
      nburst_q <= BURST_W'(1);
      mode_q   <= '0;
      lvl_q    <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dl_q     <= {(DEPTH-1){IDLE_LEVEL}};
      phi_q    <= {NCH{IDLE_LEVEL}};
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      pcnt_q  <= pcnt_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dl_q    <= taps[DEPTH-2:0];
      phi_q   <= phi_d;
      if (start_ok) begin
        mode_q   <= MODE;
        nhigh_q  <= (NHIGH == '0) ? HIGH_W'(1) : NHIGH;
        nlow_q   <= (NLOW == '0) ? LOW_W'(1) : NLOW;
        nburst_q <= (NBURST == '0) ? BURST_W'(1) : NBURST;
      end
    end
  end

  assign PHI_AZ    = phi_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PULSE_CNT = pcnt_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_jtag_az_generator_mc.sv
// Self-checking bench for jtag_az_generator_mc: a timeline model predicts every
// output cycle into a queue, and the DUT outputs are popped and compared.
module tb_jtag_az_generator_mc;

  localparam int NCH = 4, HIGH_W = 8, LOW_W = 14, PHASE_W = 5, BURST_W = 8;
  localparam int W = NCH + 2 + BURST_W;

  logic                   tck = 1'b0;
  logic                   rst, start, stop;
  logic [1:0]             mode;
  logic [HIGH_W-1:0]      nhigh;
  logic [LOW_W-1:0]       nlow;
  logic [BURST_W-1:0]     nburst;
  logic [NCH*PHASE_W-1:0] phase;
  logic [NCH-1:0]         ch_en;
  logic [NCH-1:0]         phi_az;
  logic                   busy, done;
  logic [BURST_W-1:0]     pulse_cnt;
  logic [1:0]             state_dbg;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Model state: timeline offset within the current HIGH+LOW period.
  logic               m_run, m_done, m_l;
  logic [BURST_W-1:0] m_pcnt, m_nb;
  logic [1:0]         m_mode;
  logic [NCH-1:0]     m_phi;
  int                 m_off, m_h, m_lo;
  logic               m_hist[32];

  jtag_az_generator_mc dut (
    .TCK(tck), .RESET(rst), .START(start), .STOP(stop), .MODE(mode),
    .NHIGH(nhigh), .NLOW(nlow), .NBURST(nburst), .PHASE(phase), .CH_EN(ch_en),
    .PHI_AZ(phi_az), .BUSY(busy), .DONE(done), .PULSE_CNT(pulse_cnt),
    .STATE_DBG(state_dbg)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predicts outputs for the next cycle from the inputs of this cycle.
  task automatic model_step();
    for (int k = 0; k < NCH; k++)
      m_phi[k] = ch_en[k] ? m_hist[phase[k*PHASE_W +: PHASE_W]] : 1'b1;
    m_done = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pcnt = '0; m_l = 1'b1; m_phi = '1;
      for (int j = 0; j < 32; j++) m_hist[j] = 1'b1;
      return;
    end
    if (m_run) begin
      if (stop) begin
        m_run = 1'b0;
      end else begin
        m_off++;
        if (m_off == m_h + m_lo) begin
          m_off = 0;
          m_pcnt = m_pcnt + 1'b1;
          if (m_mode == 2'd2 || (m_mode == 2'd1 && m_pcnt == m_nb)) begin
            m_run = 1'b0; m_done = 1'b1;
          end
        end
      end
    end else if (start && !stop) begin
      m_run = 1'b1; m_off = 0; m_pcnt = '0; m_mode = mode;
      m_h  = (nhigh == 0) ? 1 : int'(nhigh);
      m_lo = (nlow == 0) ? 1 : int'(nlow);
      m_nb = (nburst == 0) ? 8'd1 : nburst;
    end
    m_l = m_run ? (m_off < m_h) : 1'b1;
    for (int j = 31; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_l;
  endtask

  task automatic tick();
    logic [W-1:0] e;
    model_step();
    exp_q.push_back({m_phi, m_run, m_done, m_pcnt});
    @(posedge tck);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("phi_az",    32'(phi_az),    32'(e[W-1 -: NCH]));
      check("busy",      32'(busy),      32'(e[BURST_W+1]));
      check("done",      32'(done),      32'(e[BURST_W]));
      check("pulse_cnt", 32'(pulse_cnt), 32'(e[BURST_W-1:0]));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input logic [1:0] md, input int h, input int l, input int nb);
    mode = md; nhigh = HIGH_W'(h); nlow = LOW_W'(l); nburst = BURST_W'(nb);
  endtask

  task automatic stop_and_flush();
    stop = 1'b1;
    ticks(36);
  endtask

  initial begin
    int cnt;
    m_run = 1'b0; m_pcnt = '0; m_l = 1'b1; m_off = 0; m_h = 1; m_lo = 1; m_nb = 8'd1;
    m_mode = '0;
    for (int j = 0; j < 32; j++) m_hist[j] = 1'b1;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg(2'd0, 3, 5, 1);
    phase = '0; ch_en = '0;
    @(negedge tck);
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Continuous 3/5, channel 1 delayed by 4, channels 2/3 disabled.
    cfg(2'd0, 3, 5, 1);
    phase = {5'd0, 5'd0, 5'd4, 5'd0};
    ch_en = 4'b0011;
    start = 1'b1;
    ticks(24);
    stop_and_flush();

    // Burst of three 2/2 pulses, all channels with distinct phases.
    cfg(2'd1, 2, 2, 3);
    phase = {5'd7, 5'd3, 5'd1, 5'd0};
    ch_en = 4'b1111;
    start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) cnt++;
    end
    check("burst_done_cnt", 32'(cnt), 32'd1);
    ticks(4);

    // Single-shot with zero lengths behaves as 1/1.
    cfg(2'd2, 0, 0, 0);
    start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) cnt++;
    end
    check("single_done_cnt", 32'(cnt), 32'd1);

    // STOP during the first LOW phase: no DONE, count held at 0.
    cfg(2'd0, 3, 5, 1);
    phase = {5'd0, 5'd0, 5'd4, 5'd0};
    ch_en = 4'b0011;
    start = 1'b1;
    ticks(6);
    stop = 1'b1;
    ticks(36);

    // START together with STOP in IDLE is dropped.
    start = 1'b1; stop = 1'b1;
    ticks(4);
    check("start_stop_idle_busy", 32'(busy), 32'd0);

    // START while busy with a new NHIGH must not re-latch or restart.
    cfg(2'd0, 3, 5, 1);
    start = 1'b1;
    ticks(2);
    nhigh = 8'd7; start = 1'b1;
    ticks(20);
    stop_and_flush();

    // RESET mid-LOW with maximum delay flushes the delay line.
    cfg(2'd0, 3, 5, 1);
    phase = {NCH{5'd31}};
    ch_en = 4'b1111;
    start = 1'b1;
    ticks(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (phi_az != 4'b1111) cnt++;
    end
    check("flush_no_low", 32'(cnt), 32'd0);

    // Randomised runs, including mid-run PHASE changes and random STOP.
    for (int r = 0; r < 8; r++) begin
      cfg(2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 3));
      phase = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      ch_en = 4'($urandom_range(0, 15));
      start = 1'b1;
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 19) == 0) stop = 1'b1;
        if ($urandom_range(0, 9) == 0) phase[4:0] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) start = 1'b1;
        tick();
      end
      stop_and_flush();
    end

    check("final_idle_busy", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_az_generator_mc.md
Name: jtag_az_generator_mc

Overview:
- Multi-channel, parametrised successor of the autozeroing PWM generator.
- Produces NCH phase-staggered PHI_AZ waveforms from one master HIGH/LOW period counter.
- Supports continuous, counted-burst and single-shot modes, with a cycle-accurate per-channel phase delay.
- Sits in the EOC JTAG/config domain and drives autozeroing of synchronous-FE macro-column groups.

Parameters:
- NCH, 4, number of output channels.
- HIGH_W, 8, width of the high-phase length.
- LOW_W, 14, width of the low-phase length.
- PHASE_W, 5, width of the per-channel phase delay; delay range is 0..2**PHASE_W-1 TCK cycles.
- BURST_W, 8, width of the burst length and of the pulse counter.
- IDLE_LEVEL, 1'b1, output level when stopped. High means autozeroing is active.

Ports:
- TCK  in  1  clock; everything is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  start pulse, sampled every cycle.
- STOP  in  1  stop pulse, sampled every cycle.
- MODE  in  2  0=continuous, 1=burst, 2=single-shot, 3=reserved (behaves as continuous).
- NHIGH  in  HIGH_W  high-phase length in TCK cycles.
- NLOW  in  LOW_W  low-phase length in TCK cycles.
- NBURST  in  BURST_W  pulses per burst.
- PHASE  in  NCH*PHASE_W  per-channel delay; channel k uses slice [k*PHASE_W +: PHASE_W].
- CH_EN  in  NCH  per-channel enable.
- PHI_AZ  out  NCH  autozeroing outputs, registered.
- BUSY  out  1  high while the generator is active.
- DONE  out  1  one-cycle pulse when a burst or single-shot completes.
- PULSE_CNT  out  BURST_W  number of completed pulses since the last START.

Behaviour:
- Reset values: state IDLE; master level L=IDLE_LEVEL; all delay-line stages=IDLE_LEVEL; PHI_AZ={NCH{IDLE_LEVEL}}; BUSY=0; DONE=0; PULSE_CNT=0.
- Configuration latching: MODE, NHIGH, NLOW and NBURST are captured on an accepted START. Later changes have no effect until the next START.
  - PHASE and CH_EN are live, quasi-static inputs.
- Zero-length guard: a latched NHIGH=0 or NLOW=0 is treated as 1. A latched NBURST=0 is treated as 1.
- FSM states and transitions:
  - IDLE: L=IDLE_LEVEL. An accepted START goes to HIGH, clears the phase counter and PULSE_CNT, and sets BUSY=1 the next cycle.
  - HIGH: L=1 for exactly NHIGH cycles, then LOW.
  - LOW: L=0 for exactly NLOW cycles. At the end of the low phase:
    - PULSE_CNT increments.
    - Continuous: go to HIGH; PULSE_CNT wraps modulo 2**BURST_W.
    - Burst: if the count reaches NBURST, go to IDLE and pulse DONE for 1 cycle (the first IDLE cycle); otherwise go to HIGH.
    - Single-shot: one pulse, then go to IDLE and pulse DONE.
- Timing: START sampled at cycle t (in IDLE) gives L=1 over cycles t+1..t+NHIGH, then L=0 over t+NHIGH+1..t+NHIGH+NLOW.
- BUSY is 1 in HIGH and LOW and 0 in IDLE. It is registered, aligned with L.
- Channel k delay line: a shift register of depth 2**PHASE_W clocked every cycle, input L.
  - PHI_AZ[k](c) = L(c-1-PHASE[k]) when CH_EN[k]=1.
  - PHI_AZ[k](c) = IDLE_LEVEL when CH_EN[k]=0.
- Delay lines keep shifting after STOP or DONE, so the return to IDLE_LEVEL reaches each channel with its own phase delay.
- A PHASE change mid-run takes effect on the next cycle. A glitch on that channel is acceptable.
- STOP in HIGH or LOW: the next state is IDLE, L=IDLE_LEVEL the next cycle, BUSY=0, and DONE is not asserted. PULSE_CNT holds its value.
- START while BUSY: ignored (no restart, no re-latch).
- START and STOP in the same cycle: STOP wins; the generator stays or goes IDLE.
- RESET overrides everything, including mid-pulse and mid-delay contents.
- Internal counters are HIGH_W and LOW_W wide. Compare against the length minus 1 without underflow; the zero guard above covers the length=0 case.

Test Plan:
- Continuous, NHIGH=3, NLOW=5, PHASE[0]=0, PHASE[1]=4, CH_EN=4'b0011, START at cycle 0 -> L low on cycles 4-8 and 12-16. PHI_AZ[0] low 5-9 and 13-17. PHI_AZ[1] low 9-13. PHI_AZ[3:2] stay 1. PULSE_CNT=1 at cycle 9.
- Burst, NBURST=3, NHIGH=2, NLOW=2 -> exactly 3 low phases. DONE=1 for one cycle at cycle 13. BUSY falls at cycle 13. PULSE_CNT=3 and holds.
- Single-shot, NHIGH=0, NLOW=0 -> treated as 1/1: L=1 at cycle 1, L=0 at cycle 2, DONE at cycle 3.
- STOP at cycle 6 during the LOW phase of the first scenario -> L=1 from cycle 7. PHI_AZ[1] returns to 1 at cycle 12. No DONE. PULSE_CNT=0.
- START and STOP together in IDLE -> stays IDLE, BUSY=0. START during BUSY with changed NHIGH -> ignored; the period is unchanged.
- RESET asserted mid-LOW with PHASE=31 -> on the next cycle all PHI_AZ=1, BUSY=0, PULSE_CNT=0, and the delay lines are flushed (no late low pulse appears).
